fetch_ctrl: RTL and testbench
=============================

FETCH_CTRL -- requirements
Module: fetch_ctrl

Interface
REQ-001 Parameter RESET_PC, default 32'h0000_0000: first fetch address after reset.
REQ-002 Parameter FIFO_DEPTH, default 2: output buffer entries; only the value 2 is supported.
REQ-003 clk  input  1  single clock; all state updates on the rising edge.
REQ-004 rst  input  1  reset, synchronous and active-high.
REQ-005 fetch_en  input  1  permits new memory requests.
REQ-006 redirect_valid  input  1  branch or jump redirect strobe.
REQ-007 redirect_pc  input  32  redirect target address.
REQ-008 imem_pc  output  32  address to instruction_memory, which has synchronous read.
REQ-009 imem_instruction  input  32  memory data, valid the cycle after imem_pc is presented.
REQ-010 out_valid  output  1  an instruction is available to decode.
REQ-011 out_ready  input  1  decode accepts this cycle.
REQ-012 out_pc  output  32  PC of the presented instruction.
REQ-013 out_instr  output  32  presented instruction word.
REQ-014 err  output  1  sticky misaligned-redirect error.

Function
REQ-015 The FSM SHALL have three states:
- IDLE -> RUN when fetch_en=1.
- RUN -> IDLE when fetch_en=0.
- IDLE or RUN -> ERROR on a redirect with redirect_pc[1:0]!=0.
- ERROR is left only by rst.
REQ-016 A request SHALL issue in cycle N only when all of the following hold:
- state=RUN and fetch_en=1;
- redirect_valid=0;
- fifo_count + inflight < 2.
REQ-017 imem_pc SHALL equal the fetch_pc register every cycle; fetch_pc SHALL advance by 4 after each issued request, wrapping from 32'hFFFF_FFFC to 32'h0.
REQ-018 A request issued in cycle N SHALL write {pc, imem_instruction} into the FIFO at the end of cycle N+1, unless it was killed.
REQ-019 With out_ready held at 1, the block SHALL sustain one instruction per cycle, and the first out_valid SHALL appear 2 cycles after the first request.
REQ-020 Output handshake:
- out_valid = FIFO non-empty.
- out_pc and out_instr come from the FIFO head.
- An entry is popped when out_valid && out_ready.
- out_pc and out_instr SHALL hold stable while out_valid=1 and out_ready=0.
REQ-021 A FIFO push and a pop in the same cycle SHALL leave the count unchanged; a push at count 2 SHALL be impossible by construction of REQ-016.
REQ-022 An aligned redirect in cycle R SHALL:
- load fetch_pc with redirect_pc;
- flush the FIFO at the end of R;
- discard the response arriving in R+1 (epoch bit);
- hold out_valid low in R+1 and R+2;
- present the redirected instruction with out_valid in R+3.
REQ-023 A handshake completing in cycle R SHALL count as consumed even though a redirect is asserted in the same cycle.
REQ-024 A redirect while fetch_en=0 SHALL update fetch_pc and flush, with the state remaining IDLE.
REQ-025 When fetch_en falls in RUN, the in-flight response SHALL still be buffered and the FIFO SHALL continue to drain normally.
REQ-026 A misaligned redirect SHALL:
- set err in the next cycle;
- flush the FIFO;
- force out_valid=0;
- stop all requests until rst.

Reset
REQ-027 While rst=1 at a rising edge, the block SHALL set: state=IDLE, fetch_pc=RESET_PC, FIFO empty, inflight=0, err=0.
REQ-028 Consequently, in the cycle after reset: out_valid=0, imem_pc=RESET_PC, out_pc=0, out_instr=0.
REQ-029 rst asserted mid-operation SHALL discard any in-flight response and all buffered entries.

Structure
REQ-030 A shared package fetch_pkg SHALL hold:
- the state enum {IDLE, RUN, ERROR};
- the width constants XLEN=32 and ILEN=32;
- the PC increment constant 4.
REQ-031 The 2-entry buffer SHALL be a sub-module fetch_fifo with push/pop/flush, a count output and 64-bit entries {pc, instr}.

Verification
REQ-032 Reset, then fetch_en=1, out_ready=1, memory word = pc -> imem_pc sequence 0,4,8; out_valid from cycle 3 after reset release; out_pc/out_instr = 0,4,8 on consecutive cycles.
REQ-033 Hold out_ready=0 for 5 cycles -> exactly 2 entries buffered, imem_pc frozen at 8, and out_pc=0 stable; release -> 0,4,8 delivered with no gaps or duplicates.
REQ-034 redirect_valid=1 with redirect_pc=0x100 at cycle R -> out_valid=0 at R+1 and R+2; out_pc=0x100 at R+3, then 0x104.
REQ-035 redirect_pc=0x102 -> err=1 next cycle, out_valid=0, imem_pc stops advancing; rst clears err and returns imem_pc to RESET_PC.
REQ-036 fetch_pc at 0xFFFF_FFF8 running -> out_pc 0xFFFF_FFF8, 0xFFFF_FFFC, 0x0000_0000.

Source files
------------

// File: rtl/fetch_pkg.sv
// Shared types and constants for the instruction fetch slice.
package fetch_pkg;

  localparam int XLEN = 32;
  localparam int ILEN = 32;
  localparam logic [XLEN-1:0] PC_INC = 32'd4;

  typedef enum logic [1:0] {
    IDLE,
    RUN,
    ERROR
  } state_e;

  typedef struct packed {
    logic [XLEN-1:0] pc;
    logic [ILEN-1:0] instr;
  } fetch_ent_t;

endpackage

// File: rtl/fetch_if.sv
// Fetch-to-decode valid/ready bundle.
interface fetch_if;
  import fetch_pkg::*;

  logic            out_valid;
  logic            out_ready;
  logic [XLEN-1:0] out_pc;
  logic [ILEN-1:0] out_instr;

  modport master (
    output out_valid,
    output out_pc,
    output out_instr,
    input  out_ready
  );

  modport slave (
    input  out_valid,
    input  out_pc,
    input  out_instr,
    output out_ready
  );

endinterface

// File: rtl/fetch_fifo.sv
// Two-entry {pc, instr} buffer between fetch and decode.
module fetch_fifo
  import fetch_pkg::*;
(
  input  logic       clk,
  input  logic       rst,
  input  logic       push,
  input  logic       pop,
  input  logic       flush,
  input  fetch_ent_t wdata,
  output fetch_ent_t rdata,
  output logic [1:0] count
);

  fetch_ent_t mem [2];
  logic       wr_ptr;
  logic       rd_ptr;
  logic       do_pop;

  assign do_pop = pop && (count != 2'd0);
  assign rdata  = mem[rd_ptr];

  always_ff @(posedge clk) begin
    if (rst || flush) begin
      wr_ptr <= 1'b0;
      rd_ptr <= 1'b0;
      count  <= 2'd0;
    end else begin
      if (push)
        wr_ptr <= ~wr_ptr;
      if (do_pop)
        rd_ptr <= ~rd_ptr;
      unique case ({push, do_pop})
        2'b10:   count <= count + 2'd1;
        2'b01:   count <= count - 2'd1;
        default: count <= count;
      endcase
    end
  end

  // Storage is cleared on reset so the idle head reads as zero.
  always_ff @(posedge clk) begin
    if (rst) begin
      mem[0] <= '0;
      mem[1] <= '0;
    end else if (push && !flush) begin
      mem[wr_ptr] <= wdata;
    end
  end

endmodule

// File: rtl/fetch_ctrl.sv
// Fetch controller: PC sequencing, sync-read imem, redirect and error.
module fetch_ctrl
  import fetch_pkg::*;
#(
  parameter logic [XLEN-1:0] RESET_PC   = 32'h0000_0000,
  parameter int              FIFO_DEPTH = 2
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            fetch_en,
  input  logic            redirect_valid,
  input  logic [XLEN-1:0] redirect_pc,
  output logic [XLEN-1:0] imem_pc,
  input  logic [ILEN-1:0] imem_instruction,
  output logic            err,
  fetch_if.master         out
);

  localparam logic [1:0] CAP = 2'(FIFO_DEPTH);

  state_e          state;
  state_e          state_n;
  logic [XLEN-1:0] fetch_pc;
  logic [XLEN-1:0] req_pc;
  logic            inflight;
  logic            req_ep;
  logic            epoch;
  logic [1:0]      count;
  logic [1:0]      used;
  logic            live;
  logic            misalign;
  logic            good_redir;
  logic            issue;
  logic            pop;
  logic            push;
  logic            flush;
  fetch_ent_t      head;
  fetch_ent_t      wdata;

  assign live       = (state != ERROR);
  assign misalign   = redirect_valid && (redirect_pc[1:0] != 2'b00);
  assign good_redir = redirect_valid && !misalign && live;
  assign pop        = out.out_valid && out.out_ready;
  // A same-cycle pop frees its slot, keeping one fetch per cycle.
  assign used       = count - {1'b0, pop} + {1'b0, inflight};
  assign issue      = (state == RUN) && fetch_en
                   && !redirect_valid && (used < CAP);
  assign push       = inflight && (req_ep == epoch);
  assign flush      = (redirect_valid && live) || !live;
  assign wdata      = '{pc: req_pc, instr: imem_instruction};

  assign imem_pc       = fetch_pc;
  assign err           = (state == ERROR);
  assign out.out_valid = (count != 2'd0) && live;
  assign out.out_pc    = head.pc;
  assign out.out_instr = head.instr;

  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= IDLE;
      fetch_pc <= RESET_PC;
      req_pc   <= '0;
      inflight <= 1'b0;
      req_ep   <= 1'b0;
      epoch    <= 1'b0;
    end else begin
      state    <= state_n;
      inflight <= issue;
      if (issue) begin
        req_pc <= fetch_pc;
        req_ep <= epoch;
      end
      if (good_redir) begin
        fetch_pc <= redirect_pc;
        epoch    <= ~epoch;
      end else if (issue) begin
        fetch_pc <= fetch_pc + PC_INC;
      end
    end
  end

  always_comb begin
    state_n = state;
    unique case (1'b1)
      live && misalign:
        state_n = ERROR;
      (state == IDLE) && fetch_en && !misalign:
        state_n = RUN;
      (state == RUN) && !fetch_en && !misalign:
        state_n = IDLE;
      default:
        state_n = state;
    endcase
  end

  fetch_fifo u_fifo (
    .clk   (clk),
    .rst   (rst),
    .push  (push),
    .pop   (pop),
    .flush (flush),
    .wdata (wdata),
    .rdata (head),
    .count (count)
  );

endmodule

// File: tb/tb_fetch_ctrl.sv
// Scoreboard bench for fetch_ctrl.
module tb_fetch_ctrl;
  import fetch_pkg::*;

  logic        clk = 1'b0;
  logic        rst;
  logic        fetch_en;
  logic        redirect_valid;
  logic [31:0] redirect_pc;
  logic [31:0] imem_pc;
  logic [31:0] imem_instruction;
  logic [31:0] salt;
  logic        err;
  int          errors = 0;
  int          checks = 0;
  logic [63:0] q[$];
  logic [63:0] exp;

  fetch_if bus ();

  fetch_ctrl dut (
    .clk              (clk),
    .rst              (rst),
    .fetch_en         (fetch_en),
    .redirect_valid   (redirect_valid),
    .redirect_pc      (redirect_pc),
    .imem_pc          (imem_pc),
    .imem_instruction (imem_instruction),
    .err              (err),
    .out              (bus)
  );

  always #5 clk = ~clk;

  always @(posedge clk)
    imem_instruction <= imem_pc ^ salt;

  function automatic logic [63:0] ent(input logic [31:0] pc);
    return {pc, pc ^ salt};
  endfunction

  task automatic do_reset();
    @(negedge clk);
    rst = 1'b1;
    fetch_en = 1'b0;
    redirect_valid = 1'b0;
    redirect_pc = '0;
    bus.out_ready = 1'b0;
    q.delete();
    @(negedge clk);
    @(negedge clk);
    rst = 1'b0;
  endtask

  task automatic test_reset();
    salt = 32'h0;
    do_reset();
    checks++;
    if (bus.out_valid !== 1'b0) begin
      errors++;
      $display("FAIL rst_valid got=%b exp=0", bus.out_valid);
    end
    checks++;
    if (imem_pc !== 32'h0) begin
      errors++;
      $display("FAIL rst_pc got=%h exp=0", imem_pc);
    end
    checks++;
    if (bus.out_pc !== 32'h0 || bus.out_instr !== 32'h0) begin
      errors++;
      $display("FAIL rst_out got=%h/%h exp=0/0",
               bus.out_pc, bus.out_instr);
    end
    checks++;
    if (err !== 1'b0) begin
      errors++;
      $display("FAIL rst_err got=%b exp=0", err);
    end
  endtask

  task automatic test_stream();
    salt = 32'h0;
    do_reset();
    fetch_en = 1'b1;
    bus.out_ready = 1'b1;
    q.push_back(ent(32'h0));
    q.push_back(ent(32'h4));
    q.push_back(ent(32'h8));
    for (int c = 0; c < 6; c++) begin
      if (c >= 1 && c <= 3) begin
        checks++;
        if (imem_pc !== 32'(4 * (c - 1))) begin
          errors++;
          $display("FAIL stream_pc c=%0d got=%h exp=%h",
                   c, imem_pc, 32'(4 * (c - 1)));
        end
      end
      checks++;
      if (bus.out_valid !== (c >= 3)) begin
        errors++;
        $display("FAIL stream_valid c=%0d got=%b exp=%b",
                 c, bus.out_valid, (c >= 3));
      end
      if (bus.out_valid && q.size() != 0) begin
        exp = q.pop_front();
        checks++;
        if ({bus.out_pc, bus.out_instr} !== exp) begin
          errors++;
          $display("FAIL stream_data c=%0d got=%h exp=%h",
                   c, {bus.out_pc, bus.out_instr}, exp);
        end
      end
      @(negedge clk);
    end
    checks++;
    if (q.size() != 0) begin
      errors++;
      $display("FAIL stream_left got=%0d exp=0", q.size());
    end
  endtask

  task automatic test_backpressure();
    int first;
    int k;
    salt = 32'hCAFE_0000;
    do_reset();
    fetch_en = 1'b1;
    bus.out_ready = 1'b0;
    q.push_back(ent(32'h0));
    q.push_back(ent(32'h4));
    q.push_back(ent(32'h8));
    repeat (4) @(negedge clk);
    for (int c = 0; c < 5; c++) begin
      checks++;
      if (dut.count !== 2'd2 || imem_pc !== 32'h8) begin
        errors++;
        $display("FAIL bp_hold count=%0d pc=%h exp=2/8",
                 dut.count, imem_pc);
      end
      checks++;
      if (bus.out_valid !== 1'b1 || bus.out_pc !== 32'h0) begin
        errors++;
        $display("FAIL bp_head v=%b pc=%h exp=1/0",
                 bus.out_valid, bus.out_pc);
      end
      @(negedge clk);
    end
    bus.out_ready = 1'b1;
    first = -1;
    k = 0;
    for (int c = 0; c < 10 && q.size() != 0; c++) begin
      if (bus.out_valid) begin
        if (k == 0) first = c;
        exp = q.pop_front();
        checks++;
        if ({bus.out_pc, bus.out_instr} !== exp
            || c != first + k) begin
          errors++;
          $display("FAIL bp_drain c=%0d got=%h exp=%h",
                   c, {bus.out_pc, bus.out_instr}, exp);
        end
        k++;
      end
      @(negedge clk);
    end
    checks++;
    if (q.size() != 0) begin
      errors++;
      $display("FAIL bp_timeout left=%0d exp=0", q.size());
    end
  endtask

  task automatic test_redirect();
    salt = 32'h1234_0000;
    do_reset();
    fetch_en = 1'b1;
    bus.out_ready = 1'b1;
    repeat (6) @(negedge clk);
    redirect_valid = 1'b1;
    redirect_pc = 32'h100;
    q.push_back(ent(32'h100));
    q.push_back(ent(32'h104));
    @(negedge clk);
    redirect_valid = 1'b0;
    for (int c = 1; c <= 4; c++) begin
      checks++;
      if (bus.out_valid !== (c >= 3)) begin
        errors++;
        $display("FAIL redir_valid R+%0d got=%b exp=%b",
                 c, bus.out_valid, (c >= 3));
      end
      if (bus.out_valid && q.size() != 0) begin
        exp = q.pop_front();
        checks++;
        if ({bus.out_pc, bus.out_instr} !== exp) begin
          errors++;
          $display("FAIL redir_data R+%0d got=%h exp=%h",
                   c, {bus.out_pc, bus.out_instr}, exp);
        end
      end
      @(negedge clk);
    end
    checks++;
    if (q.size() != 0) begin
      errors++;
      $display("FAIL redir_left got=%0d exp=0", q.size());
    end
  endtask

  task automatic test_misaligned();
    logic [31:0] hold;
    salt = 32'h0;
    do_reset();
    fetch_en = 1'b1;
    bus.out_ready = 1'b1;
    repeat (5) @(negedge clk);
    redirect_valid = 1'b1;
    redirect_pc = 32'h102;
    @(negedge clk);
    redirect_valid = 1'b0;
    hold = imem_pc;
    for (int c = 0; c < 4; c++) begin
      checks++;
      if (err !== 1'b1 || bus.out_valid !== 1'b0
          || imem_pc !== hold) begin
        errors++;
        $display("FAIL mis_err c=%0d err=%b v=%b pc=%h exp=1/0/%h",
                 c, err, bus.out_valid, imem_pc, hold);
      end
      @(negedge clk);
    end
    do_reset();
    checks++;
    if (err !== 1'b0 || imem_pc !== 32'h0) begin
      errors++;
      $display("FAIL mis_clear err=%b pc=%h exp=0/0", err, imem_pc);
    end
  endtask

  task automatic test_idle_redirect();
    salt = 32'h0;
    do_reset();
    redirect_valid = 1'b1;
    redirect_pc = 32'h40;
    @(negedge clk);
    redirect_valid = 1'b0;
    for (int c = 0; c < 3; c++) begin
      checks++;
      if (imem_pc !== 32'h40 || bus.out_valid !== 1'b0
          || err !== 1'b0) begin
        errors++;
        $display("FAIL idle_redir c=%0d pc=%h v=%b exp=40/0",
                 c, imem_pc, bus.out_valid);
      end
      @(negedge clk);
    end
  endtask

  task automatic test_wrap();
    salt = 32'h5A5A_0000;
    do_reset();
    fetch_en = 1'b1;
    bus.out_ready = 1'b1;
    redirect_valid = 1'b1;
    redirect_pc = 32'hFFFF_FFF8;
    q.push_back(ent(32'hFFFF_FFF8));
    q.push_back(ent(32'hFFFF_FFFC));
    q.push_back(ent(32'h0000_0000));
    @(negedge clk);
    redirect_valid = 1'b0;
    for (int c = 0; c < 10 && q.size() != 0; c++) begin
      if (bus.out_valid) begin
        exp = q.pop_front();
        checks++;
        if ({bus.out_pc, bus.out_instr} !== exp) begin
          errors++;
          $display("FAIL wrap_data got=%h exp=%h",
                   {bus.out_pc, bus.out_instr}, exp);
        end
      end
      @(negedge clk);
    end
    checks++;
    if (q.size() != 0) begin
      errors++;
      $display("FAIL wrap_timeout left=%0d exp=0", q.size());
    end
  endtask

  task automatic test_fetch_drop();
    salt = 32'h0BAD_0000;
    do_reset();
    fetch_en = 1'b1;
    bus.out_ready = 1'b1;
    q.push_back(ent(32'h0));
    q.push_back(ent(32'h4));
    for (int c = 0; c < 8; c++) begin
      if (c == 3) fetch_en = 1'b0;
      if (c >= 5) begin
        checks++;
        if (bus.out_valid !== 1'b0 || imem_pc !== 32'h8) begin
          errors++;
          $display("FAIL drop_idle c=%0d v=%b pc=%h exp=0/8",
                   c, bus.out_valid, imem_pc);
        end
      end
      if (bus.out_valid && q.size() != 0) begin
        exp = q.pop_front();
        checks++;
        if ({bus.out_pc, bus.out_instr} !== exp) begin
          errors++;
          $display("FAIL drop_data c=%0d got=%h exp=%h",
                   c, {bus.out_pc, bus.out_instr}, exp);
        end
      end
      @(negedge clk);
    end
    checks++;
    if (q.size() != 0) begin
      errors++;
      $display("FAIL drop_left got=%0d exp=0", q.size());
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog expired");
    $fatal(1, "watchdog");
  end

  initial begin
    rst = 1'b1;
    fetch_en = 1'b0;
    redirect_valid = 1'b0;
    redirect_pc = '0;
    bus.out_ready = 1'b0;
    salt = '0;
    test_reset();
    test_stream();
    test_backpressure();
    test_redirect();
    test_misaligned();
    test_idle_redirect();
    test_wrap();
    test_fetch_drop();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
